// File: rtl/riscv_divider_if.sv
// Execute-stage handshake and operand bus for the RV32M divide/remainder unit.
interface riscv_divider_if #(parameter int XLEN = 32);
  logic            start;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;

  modport master (output start, rs1, rs2, funct3, input result, done, busy);
  modport slave  (input start, rs1, rs2, funct3, output result, done, busy);
endinterface

// File: rtl/riscv_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one
// quotient bit per cycle, with a short path for divide-by-zero and overflow.
module riscv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  riscv_divider_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic [1:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            in_signed;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] final_res;
  logic            unused_funct3;

  assign unused_funct3 = bus.funct3[2];

  // quo_q holds the dividend magnitude on entry and becomes the quotient
  always_comb begin
    in_signed = ~bus.funct3[0];
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, div_q};
    neg_quo   = ~op_q[0] & (sign_a_q ^ sign_b_q);
    neg_rem   = ~op_q[0] & sign_a_q;

    if (special_q && div_q == '0)
      final_res = op_q[1] ? (neg_rem ? -quo_q : quo_q) : '1;
    else if (special_q)
      final_res = op_q[1] ? '0 : MIN_NEG;
    else if (op_q[1])
      final_res = neg_rem ? -rem_q : rem_q;
    else
      final_res = neg_quo ? -quo_q : quo_q;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.funct3[1:0];
          sign_a_d = in_signed & bus.rs1[XLEN-1];
          sign_b_d = in_signed & bus.rs2[XLEN-1];
          quo_d    = (in_signed & bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
          div_d    = (in_signed & bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
          rem_d    = '0;
          busy_d   = 1'b1;
          if (bus.rs2 == '0 || (in_signed && bus.rs1 == MIN_NEG && bus.rs2 == '1)) begin
            // Special cases spend one extra FIXUP cycle to keep a two-cycle latency
            special_d = 1'b1;
            counter_d = CW'(1);
            state_d   = FIXUP;
          end else begin
            special_d = 1'b0;
            counter_d = CW'(XLEN-1);
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (shifted >= {1'b0, div_q}) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (counter_q == '0)
          state_d = FIXUP;
        else
          counter_d = counter_q - CW'(1);
      end

      FIXUP: begin
        if (counter_q != '0) begin
          counter_d = counter_q - CW'(1);
        end else begin
          result_d  = final_res;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          special_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_riscv_divider.sv
// Directed-vector bench for riscv_divider: results, latency, busy window,
// ignored mid-operation starts, back-to-back launch and reset abort.
module tb_riscv_divider;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  riscv_divider_if #(.XLEN(32)) bus ();

  riscv_divider #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly one edge; returns #1 after that edge
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int bcyc);
    lat  = -1;
    bcyc = bus.busy ? 1 : 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int bcyc;
    applyStimulus(f3, a, b);
    checkOutput({tag, "_done_low"}, 32'(bus.done), 32'd0);
    waitDone(lat, bcyc);
    checkOutput({tag, "_result"}, bus.result, exp_res);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 32'(bcyc), 32'(exp_lat));
    checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.rs1    = '0;
    bus.rs2    = '0;
    bus.funct3 = F_DIV;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);

    runOp("div_20_m3",   F_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    runOp("rem_20_m3",   F_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,        33);
    runOp("divu_max_2",  F_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
    runOp("remu_max_2",  F_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,        33);
    runOp("rem_m7_2",    F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    runOp("div_m7_2",    F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    runOp("div_7_0",     F_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 2);
    runOp("remu_7_0",    F_REMU, 32'd7,         32'd0,         32'd7,        2);
    runOp("rem_min_0",   F_REM,  32'h8000_0000, 32'd0,         32'h8000_0000, 2);
    runOp("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    runOp("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        2);
    runOp("divu_no_ovf", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33);

    // Start re-asserted mid-operation with churning operands must be ignored
    applyStimulus(F_DIV, 32'd100, 32'd7);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (n == 4) begin
        bus.start = 1'b1;
        bus.rs1   = 32'd1;
        bus.rs2   = 32'd1;
      end else if (n > 4) begin
        bus.rs1 = ~bus.rs1;
        bus.rs2 = ~bus.rs2;
      end
    end
    bus.start = 1'b0;
    checkOutput("midstart_result", bus.result, 32'd14);
    checkOutput("midstart_latency", 32'(lat), 32'd33);

    runOp("b2b_remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);

    // Reset in the middle of a division discards it without a done pulse
    applyStimulus(F_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_result", bus.result, 32'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) pulses++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_done_pulses", 32'(pulses), 32'd0);
    checkOutput("abort_result_held", bus.result, 32'd0);

    runOp("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
